// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the blocks that sequence it.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ALU_SEL_W-1:0] SEL_ADD = 3'b000;
  localparam logic [ALU_SEL_W-1:0] SEL_SUB = 3'b001;
  localparam logic [ALU_SEL_W-1:0] SEL_AND = 3'b010;
  localparam logic [ALU_SEL_W-1:0] SEL_OR  = 3'b011;
  localparam logic [ALU_SEL_W-1:0] SEL_ADC = 3'b100;
  localparam logic [ALU_SEL_W-1:0] SEL_XOR = 3'b101;
  localparam logic [ALU_SEL_W-1:0] SEL_SHL = 3'b110;
  localparam logic [ALU_SEL_W-1:0] SEL_SHR = 3'b111;

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issues operand/select pairs to a combinational ALU, waits a fixed settle time,
// then captures and hands the result downstream; keeps an accumulator for chaining.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_chain,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH:0]   alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_result,
  output logic [SEL_W-1:0] out_sel,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
      $error("alu_issue_ctrl: SETTLE must lie in 1..15");
    end
  endgenerate

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       accept;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // NOTE: non-blocking assignments so every register samples pre-edge values,
  // which is what lets chain read the acc captured by the previous operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_sel    <= '0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: ;
        WAIT: begin
          if (cnt == SETTLE_LAST) begin
            out_result <= alu_result;
            out_sel    <= alu_sel;
            acc        <= alu_result[WIDTH-1:0];
            op_count   <= op_count + CNT_W'(1);
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // NOTE: placed after the case so an accept overrides the DONE->IDLE
      // transition, giving back-to-back issue on a same-edge handoff.
      if (accept) begin
        alu_a   <= in_chain ? acc : in_a;
        alu_b   <= in_b;
        alu_sel <= in_sel;
        cnt     <= '0;
        state   <= WAIT;
      end
    end
  end

endmodule
